alu_arbiter: RTL and testbench

Shares the single 16-bit `addersub_16` datapath between two requesters: the data-pointer unit (port 0, `>`/`<`) and the cell-value unit (port 1, `+`/`-`). Accepts one operation at a time over a valid/ready handshake, with round-robin arbitration, and registers operands before driving the shared adder/subtractor. It then registers the result and returns it to the granting requester over a valid/ready response handshake. It sits between the instruction sequencer's execution units and the arithmetic datapath.

---
 rtl/alu_arbiter.sv | 96 +++++++++
 tb/tb_alu_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one 16-bit adder/subtractor between the
// data-pointer unit (port 0) and the cell-value unit (port 1).

module addersub_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sub,
  output logic [15:0] y
);
  // a - b is formed as a + ~b + 1; the carry out is discarded (modulo 2^16)
  always_comb begin
    y = a + (b ^ {16{sub}}) + {15'b0, sub};
  end
endmodule

module alu_arbiter #(
  parameter bit PRIO_RESET = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic        req0_sub,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic        req1_sub,
  output logic        resp0_valid,
  input  logic        resp0_ready,
  output logic        resp1_valid,
  input  logic        resp1_ready,
  output logic [15:0] resp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state, state_n;
  logic [15:0] a_q, b_q, sum;
  logic        sub_q;
  logic        own;
  logic        last;
  logic        grant0, grant1, accept;

  addersub_16 u_addersub (
    .a   (a_q),
    .b   (b_q),
    .sub (sub_q),
    .y   (sum)
  );

  always_comb begin
    // on a tie the port that did not win last time is granted
    grant0      = req0_valid && (!req1_valid || last);
    grant1      = req1_valid && (!req0_valid || !last);
    req0_ready  = (state == IDLE) && grant0;
    req1_ready  = (state == IDLE) && grant1;
    accept      = req0_ready || req1_ready;
    resp0_valid = (state == RESP) && !own;
    resp1_valid = (state == RESP) && own;
    busy        = (state != IDLE);
    state_n     = state;
    case (state)
      IDLE:    if (accept) state_n = EXEC;
      EXEC:    state_n = RESP;
      RESP:    if (own ? resp1_ready : resp0_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      own       <= 1'b0;
      last      <= ~PRIO_RESET;
      resp_data <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sub_q     <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        own   <= grant1;
        last  <= grant1;
        a_q   <= grant1 ? req1_a   : req0_a;
        b_q   <= grant1 ? req1_b   : req0_b;
        sub_q <= grant1 ? req1_sub : req0_sub;
      end
      if (state == EXEC) resp_data <= sum;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single ops, wrap cases, round-robin,
// response backpressure and reset during an in-flight operation.

module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_sub;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready, req1_sub;
  logic [15:0] req1_a, req1_b;
  logic        resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [15:0] resp_data;
  logic        busy;

  int unsigned nvec = 0;
  int unsigned nerr = 0;

  alu_arbiter #(.PRIO_RESET(1'b0)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_sub    (req0_sub),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_sub    (req1_sub),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_data   (resp_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Single op on one port starting from an IDLE cycle, responses ready high
  task automatic run_op(input logic p, input logic [15:0] a, input logic [15:0] b,
                        input logic s, input logic [15:0] exp);
    if (p) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sub = s;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sub = s;
    end
    #2;
    chk("op_ready_own",   p ? req1_ready : req0_ready, 16'd1);
    chk("op_ready_other", p ? req0_ready : req1_ready, 16'd0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #2;
    chk("op_exec_busy",  busy, 16'd1);
    chk("op_exec_valid", p ? resp1_valid : resp0_valid, 16'd0);
    step(); #2;
    chk("op_resp_valid", p ? resp1_valid : resp0_valid, 16'd1);
    chk("op_resp_other", p ? resp0_valid : resp1_valid, 16'd0);
    chk("op_resp_data",  resp_data, exp);
    step(); #2;
    chk("op_idle_busy",  busy, 16'd0);
    chk("op_idle_valid", p ? resp1_valid : resp0_valid, 16'd0);
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
    resp0_ready = 1'b1; resp1_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    #2;
    chk("rst_busy",   busy, 16'd0);
    chk("rst_data",   resp_data, 16'h0000);
    chk("rst_resp0",  resp0_valid, 16'd0);
    chk("rst_resp1",  resp1_valid, 16'd0);
    chk("rst_ready0", req0_ready, 16'd0);
    step();

    // single-port ops and modulo wrap cases
    run_op(1'b0, 16'h0002, 16'h0002, 1'b0, 16'h0004);
    run_op(1'b1, 16'h0000, 16'h0001, 1'b1, 16'hFFFF);
    run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000);
    run_op(1'b1, 16'h1000, 16'h0100, 1'b1, 16'h0F00);
    run_op(1'b0, 16'h8000, 16'h8001, 1'b1, 16'hFFFF);

    // both ports held valid from reset: grants alternate, one op per 3 cycles
    rst = 1'b1;
    step();
    req0_valid = 1'b1; req0_a = 16'h0001; req0_b = 16'h0001; req0_sub = 1'b0;
    req1_valid = 1'b1; req1_a = 16'h0010; req1_b = 16'h0003; req1_sub = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk("rr_ready0", req0_ready, (i % 2 == 0) ? 16'd1 : 16'd0);
      chk("rr_ready1", req1_ready, (i % 2 == 1) ? 16'd1 : 16'd0);
      step(); #2;
      chk("rr_exec_ready", {15'b0, req0_ready | req1_ready}, 16'd0);
      chk("rr_exec_busy",  busy, 16'd1);
      step(); #2;
      chk("rr_resp0", resp0_valid, (i % 2 == 0) ? 16'd1 : 16'd0);
      chk("rr_resp1", resp1_valid, (i % 2 == 1) ? 16'd1 : 16'd0);
      chk("rr_data",  resp_data, (i % 2 == 0) ? 16'h0002 : 16'h000D);
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;

    // backpressure on port 0 while port 1 waits
    req0_valid = 1'b1; req0_a = 16'h0008; req0_b = 16'h0008; req0_sub = 1'b0;
    #2;
    chk("bp_accept0", req0_ready, 16'd1);
    step();
    req0_valid = 1'b0; resp0_ready = 1'b0;
    step();
    req1_valid = 1'b1; req1_a = 16'h0005; req1_b = 16'h0003; req1_sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #2;
      chk("bp_valid", resp0_valid, 16'd1);
      chk("bp_data",  resp_data, 16'h0010);
      chk("bp_req1",  req1_ready, 16'd0);
      chk("bp_busy",  busy, 16'd1);
      step();
    end
    resp0_ready = 1'b1;
    #2;
    chk("bp_release_valid", resp0_valid, 16'd1);
    chk("bp_release_req1",  req1_ready, 16'd0);
    step(); #2;
    chk("bp_idle_busy",   busy, 16'd0);
    chk("bp_accept1",     req1_ready, 16'd1);
    chk("bp_resp0_clear", resp0_valid, 16'd0);
    step();
    req1_valid = 1'b0;
    step(); #2;
    chk("bp_resp1_valid", resp1_valid, 16'd1);
    chk("bp_resp1_data",  resp_data, 16'h0008);
    step();

    // reset during EXEC drops the op
    req0_valid = 1'b1; req0_a = 16'h1234; req0_b = 16'h0001; req0_sub = 1'b0;
    #2;
    chk("mr_accept", req0_ready, 16'd1);
    step();
    req0_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    #2;
    chk("mr_busy",  busy, 16'd0);
    chk("mr_data",  resp_data, 16'h0000);
    chk("mr_resp0", resp0_valid, 16'd0);
    for (int i = 0; i < 2; i++) begin
      step(); #2;
      chk("mr_no_resp0", resp0_valid, 16'd0);
      chk("mr_no_resp1", resp1_valid, 16'd0);
    end
    step();
    run_op(1'b1, 16'h0007, 16'h0002, 1'b1, 16'h0005);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
